// File: rtl/ps2_scan_rx_pkg.sv
// Shared constants, state encoding and helpers for the PS/2 scan-code receiver.
package ps2_pkg;

  // Prefix bytes that modify the next scan code.
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  // Keyboard status/reply bytes that never form a key event.
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_OVF0   = 8'h00;
  localparam logic [7:0] PS2_OVF1   = 8'hFF;

  // Event word layout.
  localparam int KEY_W        = 11;
  localparam int KEY_TOGGLE   = 10;
  localparam int KEY_PRESSED  = 9;
  localparam int KEY_EXT      = 8;
  localparam int KEY_CODE_MSB = 7;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

  // Bytes swallowed without touching the prefix flags (E1 included, so the
  // Pause sequence degrades to plain events for its trailing codes).
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == PS2_PAUSE) || (b == PS2_BAT_OK) || (b == PS2_ACK) ||
           (b == PS2_ECHO)  || (b == PS2_RESEND) || (b == PS2_OVF0) ||
           (b == PS2_OVF1);
  endfunction

endpackage

// File: rtl/ps2_scan_rx_if.sv
// Pin and event-word bundle between the PS/2 pins and the key-mapping logic.
interface ps2_scan_rx_if;
  import ps2_pkg::*;

  logic             ps2_clk;
  logic             ps2_data;
  logic [KEY_W-1:0] ps2_key;
  logic             err_strobe;
  logic             busy;

  // Side that drives the raw pins and consumes events.
  modport master (
    output ps2_clk, ps2_data,
    input  ps2_key, err_strobe, busy
  );

  // Receiver side.
  modport slave (
    input  ps2_clk, ps2_data,
    output ps2_key, err_strobe, busy
  );
endinterface

// File: rtl/ps2_scan_rx_line_filter.sv
// Two-flop synchroniser followed by a persistence filter: the output only
// follows the input after FILTER_LEN consecutive differing samples.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Metastability guard; idles high like an undriven PS/2 line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // Count consecutive disagreeing samples; any agreeing sample restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= 1'b1;
      cnt  <= '0;
    end else if (sync2 != dout) begin
      if (cnt == CW'(FILTER_LEN - 1)) begin
        dout <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt <= '0;
    end
  end
endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: filters the pins, deframes 11-bit frames, folds
// E0/F0 prefixes and emits toggle-flagged key events.
module ps2_scan_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 48000
) (
  input  logic         clk_sys,
  input  logic         RESET,
  ps2_scan_rx_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // Index 0 = clock pin, index 1 = data pin.
  logic [1:0] raw_pins;
  logic [1:0] filt;

  assign raw_pins = {bus.ps2_data, bus.ps2_clk};

  for (genvar gi = 0; gi < 2; gi++) begin : g_filt
    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
      .clk  (clk_sys),
      .rst  (RESET),
      .din  (raw_pins[gi]),
      .dout (filt[gi])
    );
  end

  logic             clk_f;
  logic             data_f;
  logic             clk_f_d;
  logic             sample;
  logic             timeout_hit;
  logic             frame_ok;
  logic [TW-1:0]    tcnt;
  ps2_state_t       state;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             par;
  logic             ext;
  logic             brk;
  logic [KEY_W-1:0] key_reg;
  logic             err_reg;
  logic             busy_reg;

  assign clk_f  = filt[0];
  assign data_f = filt[1];
  assign sample = clk_f_d & ~clk_f;

  // A sample event in the expiry cycle wins, so the bit is never lost to a race.
  assign timeout_hit = (state != IDLE) && !sample &&
                       (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign frame_ok    = data_f && (^{shreg, par});

  // Delayed filtered clock for falling-edge detection.
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) clk_f_d <= 1'b1;
    else       clk_f_d <= clk_f;
  end

  // Cycles since the last sample event while a frame is open.
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET)                       tcnt <= '0;
    else if (state == IDLE || sample) tcnt <= '0;
    else                             tcnt <= tcnt + TW'(1);
  end

  // Frame FSM with the byte/prefix layer folded into the stop-bit step.
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      ext      <= 1'b0;
      brk      <= 1'b0;
      key_reg  <= '0;
      err_reg  <= 1'b0;
      busy_reg <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      if (timeout_hit) begin
        state    <= IDLE;
        busy_reg <= 1'b0;
        ext      <= 1'b0;
        brk      <= 1'b0;
        err_reg  <= 1'b1;
      end else if (sample) begin
        case (state)
          IDLE: begin
            if (!data_f) begin
              state    <= DATA;
              bit_cnt  <= '0;
              busy_reg <= 1'b1;
            end else begin
              ext     <= 1'b0;
              brk     <= 1'b0;
              err_reg <= 1'b1;
            end
          end
          DATA: begin
            shreg   <= {data_f, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= data_f;
            state <= STOP;
          end
          STOP: begin
            state    <= IDLE;
            busy_reg <= 1'b0;
            if (!frame_ok) begin
              ext     <= 1'b0;
              brk     <= 1'b0;
              err_reg <= 1'b1;
            end else if (shreg == PS2_EXT) begin
              ext <= 1'b1;
            end else if (shreg == PS2_BRK) begin
              brk <= 1'b1;
            end else if (!is_ignored(shreg)) begin
              key_reg <= {~key_reg[KEY_TOGGLE], ~brk, ext, shreg};
              ext     <= 1'b0;
              brk     <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.ps2_key    = key_reg;
  assign bus.err_strobe = err_reg;
  assign bus.busy       = busy_reg;
endmodule
